// File: rtl/rs_pkg.sv
// Shared types and constants for the integer reservation station.
// Holds the entry layout, the ALU op encodings and the wakeup match helper.
package rs_pkg;

  localparam int RS_XLEN   = 32;
  localparam int TAG_W     = 5;
  localparam int EXEC_RS_W = 73;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLL  = 4'b0010,
    ALU_SLT  = 4'b0100,
    ALU_SLTU = 4'b0110,
    ALU_XOR  = 4'b1000,
    ALU_SRL  = 4'b1010,
    ALU_SRA  = 4'b1011,
    ALU_OR   = 4'b1100,
    ALU_AND  = 4'b1110
  } alu_op_e;

  typedef struct packed {
    logic               valid;
    logic [3:0]         aluop;
    logic [TAG_W-1:0]   rd;
    logic [RS_XLEN-1:0] op1;
    logic               op1_rdy;
    logic [TAG_W-1:0]   op1_tag;
    logic [RS_XLEN-1:0] op2;
    logic               op2_rdy;
    logic [TAG_W-1:0]   op2_tag;
  } rs_entry_t;

  // Register 0 is hardwired, so a completion to rd 0 never satisfies a waiting operand.
  function automatic logic cdb_match(input logic             cdb_valid,
                                     input logic [TAG_W-1:0] cdb_rd,
                                     input logic             rdy,
                                     input logic [TAG_W-1:0] tag);
    return cdb_valid && (cdb_rd != '0) && !rdy && (tag == cdb_rd);
  endfunction

endpackage

// File: rtl/rs_pick_lowest.sv
// One-hot priority picker: grants the lowest set bit of req; any flags a non-empty request.
// Purely combinational.
module rs_pick_lowest #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         any
);

  always_comb begin
    gnt = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/rs_integer.sv
// Integer reservation station: buffers dispatched ops, snoops the completion bus for
// missing operands, issues the lowest-index ready entry each cycle through a register.
module rs_integer
  import rs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 dispatch_valid,
  output logic                 dispatch_ready,
  input  logic [3:0]           dispatch_aluop,
  input  logic [4:0]           dispatch_rd,
  input  logic [XLEN-1:0]      dispatch_op1,
  input  logic                 dispatch_op1_rdy,
  input  logic [4:0]           dispatch_op1_tag,
  input  logic [XLEN-1:0]      dispatch_op2,
  input  logic                 dispatch_op2_rdy,
  input  logic [4:0]           dispatch_op2_tag,
  input  logic                 cdb_valid,
  input  logic [4:0]           cdb_rd,
  input  logic [XLEN-1:0]      cdb_result,
  output logic                 exec_enable,
  output logic [EXEC_RS_W-1:0] exec_rs,
  output logic [3:0]           free_count
);

  localparam logic [3:0] DEPTH_CNT = 4'(DEPTH);

  rs_entry_t        ent     [DEPTH];
  rs_entry_t        ent_nxt [DEPTH];
  rs_entry_t        new_ent;
  rs_entry_t        iss_ent;
  logic [DEPTH-1:0] free_vec;
  logic [DEPTH-1:0] rdy_vec;
  logic [DEPTH-1:0] free_oh;
  logic [DEPTH-1:0] iss_oh;
  logic             free_any;
  logic             iss_any;
  logic             accept;
  logic             issue;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      free_vec[i] = !ent[i].valid;
      rdy_vec[i]  = ent[i].valid && ent[i].op1_rdy && ent[i].op2_rdy;
    end
  end

  rs_pick_lowest #(.N(DEPTH)) u_pick_free (
    .req (free_vec),
    .gnt (free_oh),
    .any (free_any)
  );

  rs_pick_lowest #(.N(DEPTH)) u_pick_issue (
    .req (rdy_vec),
    .gnt (iss_oh),
    .any (iss_any)
  );

  // Readiness comes from registered free_count, so an issue never frees room for the same-cycle dispatch.
  assign dispatch_ready = (free_count != 4'd0);
  assign accept         = dispatch_valid && dispatch_ready && free_any && !flush;
  assign issue          = iss_any && !flush;

  always_comb begin
    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.aluop   = dispatch_aluop;
    new_ent.rd      = dispatch_rd;
    new_ent.op1     = dispatch_op1;
    new_ent.op1_rdy = dispatch_op1_rdy;
    new_ent.op1_tag = dispatch_op1_tag;
    new_ent.op2     = dispatch_op2;
    new_ent.op2_rdy = dispatch_op2_rdy;
    new_ent.op2_tag = dispatch_op2_tag;
    if (cdb_match(cdb_valid, cdb_rd, dispatch_op1_rdy, dispatch_op1_tag)) begin
      new_ent.op1     = cdb_result;
      new_ent.op1_rdy = 1'b1;
    end
    if (cdb_match(cdb_valid, cdb_rd, dispatch_op2_rdy, dispatch_op2_tag)) begin
      new_ent.op2     = cdb_result;
      new_ent.op2_rdy = 1'b1;
    end
  end

  always_comb begin
    iss_ent = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (iss_oh[i]) iss_ent = ent[i];
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_nxt[i] = ent[i];
      if (ent[i].valid && cdb_match(cdb_valid, cdb_rd, ent[i].op1_rdy, ent[i].op1_tag)) begin
        ent_nxt[i].op1     = cdb_result;
        ent_nxt[i].op1_rdy = 1'b1;
      end
      if (ent[i].valid && cdb_match(cdb_valid, cdb_rd, ent[i].op2_rdy, ent[i].op2_tag)) begin
        ent_nxt[i].op2     = cdb_result;
        ent_nxt[i].op2_rdy = 1'b1;
      end
      if (issue && iss_oh[i]) ent_nxt[i].valid = 1'b0;
      if (accept && free_oh[i]) ent_nxt[i] = new_ent;
      if (flush) ent_nxt[i].valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= ent_nxt[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      free_count <= DEPTH_CNT;
    end else if (flush) begin
      free_count <= DEPTH_CNT;
    end else begin
      case ({accept, issue})
        2'b10:   free_count <= free_count - 4'd1;
        2'b01:   free_count <= free_count + 4'd1;
        default: free_count <= free_count;
      endcase
    end
  end

  // exec_rs deliberately holds its last word when nothing issues.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exec_enable <= 1'b0;
      exec_rs     <= '0;
    end else begin
      exec_enable <= issue;
      if (issue) exec_rs <= {iss_ent.aluop, iss_ent.rd, iss_ent.op1, iss_ent.op2};
    end
  end

endmodule

// File: tb/tb_rs_integer.sv
// Directed bench for rs_integer with hand-computed issue words and counters.
module tb_rs_integer;
  import rs_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        dispatch_valid;
  logic        dispatch_ready;
  logic [3:0]  dispatch_aluop;
  logic [4:0]  dispatch_rd;
  logic [31:0] dispatch_op1;
  logic        dispatch_op1_rdy;
  logic [4:0]  dispatch_op1_tag;
  logic [31:0] dispatch_op2;
  logic        dispatch_op2_rdy;
  logic [4:0]  dispatch_op2_tag;
  logic        cdb_valid;
  logic [4:0]  cdb_rd;
  logic [31:0] cdb_result;
  logic        exec_enable;
  logic [72:0] exec_rs;
  logic [3:0]  free_count;

  int n_checks = 0;
  int n_errors = 0;

  rs_integer #(.DEPTH(4), .XLEN(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .dispatch_valid   (dispatch_valid),
    .dispatch_ready   (dispatch_ready),
    .dispatch_aluop   (dispatch_aluop),
    .dispatch_rd      (dispatch_rd),
    .dispatch_op1     (dispatch_op1),
    .dispatch_op1_rdy (dispatch_op1_rdy),
    .dispatch_op1_tag (dispatch_op1_tag),
    .dispatch_op2     (dispatch_op2),
    .dispatch_op2_rdy (dispatch_op2_rdy),
    .dispatch_op2_tag (dispatch_op2_tag),
    .cdb_valid        (cdb_valid),
    .cdb_rd           (cdb_rd),
    .cdb_result       (cdb_result),
    .exec_enable      (exec_enable),
    .exec_rs          (exec_rs),
    .free_count       (free_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [72:0] act, input logic [72:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dispatch_valid = 1'b0;
    cdb_valid      = 1'b0;
    cdb_rd         = 5'd0;
    cdb_result     = 32'd0;
    flush          = 1'b0;
  endtask

  // Operand 2 is always supplied ready; operand 1 may wait on a tag.
  task automatic disp(input logic [3:0] op, input logic [4:0] rd, input logic [31:0] a,
                      input logic ardy, input logic [4:0] atag, input logic [31:0] b);
    dispatch_valid   = 1'b1;
    dispatch_aluop   = op;
    dispatch_rd      = rd;
    dispatch_op1     = a;
    dispatch_op1_rdy = ardy;
    dispatch_op1_tag = atag;
    dispatch_op2     = b;
    dispatch_op2_rdy = 1'b1;
    dispatch_op2_tag = 5'd0;
  endtask

  task automatic cdb(input logic [4:0] rd, input logic [31:0] res);
    cdb_valid  = 1'b1;
    cdb_rd     = rd;
    cdb_result = res;
  endtask

  function automatic logic [72:0] word(input logic [3:0] op, input logic [4:0] rd,
                                       input logic [31:0] a, input logic [31:0] b);
    return {op, rd, a, b};
  endfunction

  initial begin
    reset = 1'b1;
    idle();
    disp(4'd0, 5'd0, 32'd0, 1'b1, 5'd0, 32'd0);
    dispatch_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_en", 73'(exec_enable), 73'd0);
    chk("rst_rs", exec_rs, 73'd0);
    chk("rst_free", 73'(free_count), 73'd4);
    chk("rst_rdy", 73'(dispatch_ready), 73'd1);

    // 1: fully ready ADD issues after the second edge
    disp(ALU_ADD, 5'd3, 32'd5, 1'b1, 5'd0, 32'd7);
    tick();
    idle();
    chk("t1_en_n", 73'(exec_enable), 73'd0);
    chk("t1_free_n", 73'(free_count), 73'd3);
    tick();
    chk("t1_en", 73'(exec_enable), 73'd1);
    chk("t1_rs", exec_rs, {4'b0000, 5'd3, 32'd5, 32'd7});
    chk("t1_free", 73'(free_count), 73'd4);
    tick();
    chk("t1_en_off", 73'(exec_enable), 73'd0);

    // 2: SUB waits for r3, woken by completion bus
    disp(ALU_SUB, 5'd4, 32'd0, 1'b0, 5'd3, 32'd1);
    tick();
    idle();
    tick();
    chk("t2_wait", 73'(exec_enable), 73'd0);
    cdb(5'd3, 32'd10);
    tick();
    idle();
    chk("t2_wake_edge", 73'(exec_enable), 73'd0);
    tick();
    chk("t2_en", 73'(exec_enable), 73'd1);
    chk("t2_rs", exec_rs, word(ALU_SUB, 5'd4, 32'd10, 32'd1));

    // 3: dispatch bypass, then rd 0 never wakes
    disp(ALU_XOR, 5'd7, 32'd0, 1'b0, 5'd6, 32'd2);
    cdb(5'd6, 32'hDEAD);
    tick();
    idle();
    tick();
    chk("t3_byp_en", 73'(exec_enable), 73'd1);
    chk("t3_byp_rs", exec_rs, word(ALU_XOR, 5'd7, 32'hDEAD, 32'd2));
    disp(ALU_OR, 5'd8, 32'd0, 1'b0, 5'd0, 32'd3);
    cdb(5'd0, 32'h55);
    tick();
    dispatch_valid = 1'b0;
    tick();
    tick();
    chk("t3_r0_en", 73'(exec_enable), 73'd0);
    chk("t3_r0_free", 73'(free_count), 73'd3);
    idle();
    flush = 1'b1;
    tick();
    idle();
    chk("t3_flush_free", 73'(free_count), 73'd4);

    // 4: fill all slots blocked on tags 10..13
    disp(ALU_ADD, 5'd10, 32'd0, 1'b0, 5'd10, 32'd100);
    tick();
    disp(ALU_SLL, 5'd11, 32'd0, 1'b0, 5'd11, 32'd101);
    tick();
    disp(ALU_SLT, 5'd12, 32'd0, 1'b0, 5'd12, 32'd102);
    tick();
    disp(ALU_XOR, 5'd13, 32'd0, 1'b0, 5'd13, 32'd103);
    tick();
    chk("t4_full_rdy", 73'(dispatch_ready), 73'd0);
    chk("t4_full_free", 73'(free_count), 73'd0);
    disp(ALU_SRA, 5'd20, 32'd0, 1'b0, 5'd14, 32'd5);
    tick();
    chk("t4_full_hold", 73'(free_count), 73'd0);
    dispatch_valid = 1'b0;
    cdb(5'd12, 32'h100);
    tick();
    cdb_valid = 1'b0;
    chk("t4_wake_edge", 73'(exec_enable), 73'd0);
    disp(ALU_SRA, 5'd20, 32'd0, 1'b0, 5'd14, 32'd5);
    tick();
    dispatch_valid = 1'b0;
    chk("t4_iss_en", 73'(exec_enable), 73'd1);
    chk("t4_iss_rs", exec_rs, word(ALU_SLT, 5'd12, 32'h100, 32'd102));
    chk("t4_no_same_cyc", 73'(free_count), 73'd1);
    cdb(5'd10, 32'h200);
    tick();
    cdb_valid = 1'b0;
    disp(ALU_SRA, 5'd20, 32'd0, 1'b0, 5'd14, 32'd5);
    tick();
    idle();
    chk("t4_acc_iss_en", 73'(exec_enable), 73'd1);
    chk("t4_acc_iss_rs", exec_rs, word(ALU_ADD, 5'd10, 32'h200, 32'd100));
    chk("t4_acc_iss_free", 73'(free_count), 73'd1);
    flush = 1'b1;
    tick();
    idle();

    // 5: slots 1 and 3 wake together, lower index first
    disp(ALU_ADD, 5'd0, 32'd0, 1'b0, 5'd5, 32'd0);
    tick();
    disp(ALU_OR, 5'd1, 32'd0, 1'b0, 5'd9, 32'd11);
    tick();
    disp(ALU_ADD, 5'd2, 32'd0, 1'b0, 5'd6, 32'd0);
    tick();
    disp(ALU_AND, 5'd3, 32'd0, 1'b0, 5'd9, 32'd33);
    tick();
    idle();
    cdb(5'd9, 32'h99);
    tick();
    idle();
    tick();
    chk("t5_first_en", 73'(exec_enable), 73'd1);
    chk("t5_first_rs", exec_rs, word(ALU_OR, 5'd1, 32'h99, 32'd11));
    tick();
    chk("t5_second_en", 73'(exec_enable), 73'd1);
    chk("t5_second_rs", exec_rs, word(ALU_AND, 5'd3, 32'h99, 32'd33));
    tick();
    chk("t5_done_en", 73'(exec_enable), 73'd0);
    chk("t5_done_free", 73'(free_count), 73'd2);

    // 6a: asynchronous reset with three entries held
    disp(ALU_SUB, 5'd6, 32'd0, 1'b0, 5'd7, 32'd0);
    tick();
    idle();
    chk("t6_held_free", 73'(free_count), 73'd1);
    reset = 1'b1;
    #2;
    chk("t6_rst_free", 73'(free_count), 73'd4);
    chk("t6_rst_en", 73'(exec_enable), 73'd0);
    chk("t6_rst_rdy", 73'(dispatch_ready), 73'd1);
    tick();
    reset = 1'b0;
    cdb(5'd5, 32'd1);
    tick();
    cdb(5'd6, 32'd2);
    tick();
    cdb(5'd7, 32'd3);
    tick();
    idle();
    tick();
    chk("t6_rst_noiss", 73'(exec_enable), 73'd0);
    chk("t6_rst_free2", 73'(free_count), 73'd4);

    // 6b: flush with a ready entry and same-cycle dispatch/cdb
    disp(ALU_ADD, 5'd1, 32'd0, 1'b0, 5'd7, 32'd0);
    tick();
    disp(ALU_ADD, 5'd2, 32'd0, 1'b0, 5'd8, 32'd0);
    tick();
    disp(ALU_SRL, 5'd9, 32'd1, 1'b1, 5'd0, 32'd2);
    tick();
    chk("t6_pre_free", 73'(free_count), 73'd1);
    disp(ALU_ADD, 5'd3, 32'd4, 1'b1, 5'd0, 32'd4);
    cdb(5'd7, 32'd77);
    flush = 1'b1;
    tick();
    idle();
    chk("t6_fl_en", 73'(exec_enable), 73'd0);
    chk("t6_fl_free", 73'(free_count), 73'd4);
    cdb(5'd8, 32'd88);
    tick();
    idle();
    tick();
    chk("t6_fl_noiss", 73'(exec_enable), 73'd0);
    tick();
    chk("t6_fl_noiss2", 73'(exec_enable), 73'd0);
    chk("t6_fl_free2", 73'(free_count), 73'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
